ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 10 +
 rtl/ifetch_if.sv | 28 ++
 rtl/ifetch_fifo.sv | 44 ++++
 rtl/ifetch.sv | 86 ++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared FSM states, default widths and buffer entry type for the instruction fetch unit.
package ifetch_pkg;
  localparam int ADR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, REQ, STEP, DISCARD} state_t;
  typedef struct packed {
    logic [ADR_W_DEF-1:0]  adr;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: PC, branch, program-memory and instruction-output signals of the fetch unit.
interface ifetch_if import ifetch_pkg::*; #(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADR_W-1:0]  pc_adr;
  logic              pc_enable;
  logic              pc_load;
  logic [ADR_W-1:0]  pc_nxt_adr;
  logic              branch_valid;
  logic [ADR_W-1:0]  branch_adr;
  logic              mem_req;
  logic [ADR_W-1:0]  mem_adr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADR_W-1:0]  instr_adr;
  logic              instr_ready;
  modport master (
    input  pc_adr, branch_valid, branch_adr, mem_ack, mem_data, instr_ready,
    output pc_enable, pc_load, pc_nxt_adr, mem_req, mem_adr, instr_valid, instr_data, instr_adr
  );
  modport slave (
    output pc_adr, branch_valid, branch_adr, mem_ack, mem_data, instr_ready,
    input  pc_enable, pc_load, pc_nxt_adr, mem_req, mem_adr, instr_valid, instr_data, instr_adr
  );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry instruction buffer with push/pop/flush; head read straight from storage.
module ifetch_fifo import ifetch_pkg::*; #(
  parameter int DEPTH = 2,
  parameter type T = entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic wr, rd;
  assign wr = push && !full;
  assign rd = pop && !empty;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (rd) rp <= rp + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/ifetch.sv
// ifetch: fetch FSM feeding a valid/ready instruction buffer; branches flush and discard in-flight reads.
// Define IFETCH_STATS_EN to add saturating fetch_cnt/discard_cnt outputs.
module ifetch import ifetch_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int ADR_W = ADR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic reset,
  ifetch_if.master bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [7:0]  discard_cnt
`endif
);
  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } ent_t;
  state_t state, nxt;
  logic [ADR_W-1:0] adr_q;
  logic push, full, empty;
  ent_t din, head;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      adr_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == REQ) adr_q <= bus.pc_adr;
    end
  always_comb begin
    nxt = state;
    push = 1'b0;
    bus.mem_req = 1'b0;
    bus.pc_enable = 1'b0;
    case (state)
      IDLE: nxt = (!bus.branch_valid && !full) ? REQ : IDLE;
      REQ: begin
        bus.mem_req = 1'b1;
        push = bus.mem_ack && !bus.branch_valid;
        nxt = bus.mem_ack ? (bus.branch_valid ? IDLE : STEP) : (bus.branch_valid ? DISCARD : REQ);
      end
      STEP: begin
        bus.pc_enable = !bus.branch_valid;
        nxt = IDLE;
      end
      DISCARD: begin
        bus.mem_req = 1'b1;
        nxt = bus.mem_ack ? IDLE : DISCARD;
      end
      default: nxt = IDLE;
    endcase
  end
  assign din = '{adr: adr_q, data: bus.mem_data};
  ifetch_fifo #(.DEPTH(DEPTH), .T(ent_t)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(bus.instr_ready),
    .flush(bus.branch_valid),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign bus.pc_load = bus.branch_valid;
  assign bus.pc_nxt_adr = bus.branch_adr;
  assign bus.mem_adr = adr_q;
  assign bus.instr_valid = !empty;
  assign bus.instr_data = head.data;
  assign bus.instr_adr = head.adr;
`ifdef IFETCH_STATS_EN
  logic drop;
  assign drop = bus.mem_ack && (state == DISCARD || (state == REQ && bus.branch_valid));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_cnt <= '0;
      discard_cnt <= '0;
    end else begin
      if (push && !(&fetch_cnt)) fetch_cnt <= fetch_cnt + 16'd1;
      if (drop && !(&discard_cnt)) discard_cnt <= discard_cnt + 8'd1;
    end
`endif
endmodule
